alu_exec_unit: RTL and testbench

- Execute stage that directly consumes the 4-bit ALU control code from the ALU controller, plus the register/immediate operands.
- Single-cycle ops return a registered result one cycle after start.
- Code 11 (MULT) runs an iterative signed shift-add multiply over WIDTH cycles and writes HI/LO.
- A start/busy/done handshake lets the CPU control stall the pipeline while a multiply is in flight.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/seq_multiplier.sv | 82 ++++++++
 rtl/alu_exec_unit.sv | 107 ++++++++++
 tb/tb_alu_exec_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, multiplier FSM encoding and default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRLV = 4'd6;
    localparam logic [3:0] ALU_BEQ  = 4'd7;
    localparam logic [3:0] ALU_LUI  = 4'd8;
    localparam logic [3:0] ALU_ORI  = 4'd9;
    localparam logic [3:0] ALU_BNE  = 4'd10;
    localparam logic [3:0] ALU_MULT = 4'd11;
    localparam logic [3:0] ALU_NOP  = 4'd12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative signed shift-add multiplier, one multiplier bit per cycle.
// Optional MULT_EARLY_EXIT_EN stops once the remaining multiplier bits are all zero.
module seq_multiplier import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product
);

    mul_state_t               state;
    logic [CNT_W-1:0]         cnt;
    logic [2*WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]         mplier;
    logic [2*WIDTH-1:0]       acc;
    logic [2*WIDTH-1:0]       acc_nxt;
    logic                     sign;

    // Magnitude as an unsigned value, so the most-negative input maps to 2**(WIDTH-1) exactly.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : '0);
`ifdef MULT_EARLY_EXIT_EN
        last = (state == ST_MUL) &&
               ((cnt == CNT_W'(WIDTH-1)) || (mplier[WIDTH-1:1] == '0));
`else
        last = (state == ST_MUL) && (cnt == CNT_W'(WIDTH-1));
`endif
    end

    assign busy = (state == ST_MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            sign    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, magnitude(a)};
                        mplier <= magnitude(b);
                        sign   <= a[WIDTH-1] ^ b[WIDTH-1];
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        product <= sign ? (~acc_nxt + 1'b1) : acc_nxt;
                        done    <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ALU ops with registered result, plus a handshaked iterative MULT.
// MULT_EARLY_EXIT_EN (optional) enables early termination inside seq_multiplier.
module alu_exec_unit import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [4:0]       shamt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             branch_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic                   accept_op;
    logic                   accept_mul;
    logic [WIDTH-1:0]       op_result;
    logic                   op_branch;
    logic [WIDTH-1:0]       result_q;
    logic                   branch_q;
    logic                   sel_mul;
    logic                   op_done;
    logic                   mul_done;
    logic                   mul_last;
    logic [2*WIDTH-1:0]     product;
    logic signed [WIDTH-1:0] src1_s;
    logic signed [WIDTH-1:0] src2_s;

    assign src1_s     = src1_i;
    assign src2_s     = src2_i;
    assign accept_op  = start_i && !busy_o && (ctrl_i != ALU_MULT);
    assign accept_mul = start_i && !busy_o && (ctrl_i == ALU_MULT);

    always_comb begin
        op_result = '0;
        op_branch = 1'b0;
        case (ctrl_i)
            ALU_AND:  op_result = src1_i & src2_i;
            ALU_OR:   op_result = src1_i | src2_i;
            ALU_ADD:  op_result = src1_i + src2_i;
            ALU_SUB:  op_result = src1_i - src2_i;
            ALU_SLT:  op_result = (src1_s < src2_s) ? WIDTH'(1) : '0;
            ALU_SLL:  op_result = src2_i << shamt_i;
            ALU_SRLV: op_result = src2_i >> src1_i[4:0];
            ALU_BEQ: begin
                op_result = src1_i - src2_i;
                op_branch = (src1_i == src2_i);
            end
            ALU_LUI:  op_result = src2_i << 16;
            ALU_ORI:  op_result = src1_i | {{(WIDTH-16){1'b0}}, src2_i[15:0]};
            ALU_BNE: begin
                op_result = src1_i - src2_i;
                op_branch = (src1_i != src2_i);
            end
            default:  op_result = '0;
        endcase
    end

    seq_multiplier #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mult (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .start   (accept_mul),
        .a       (src1_i),
        .b       (src2_i),
        .busy    (busy_o),
        .done    (mul_done),
        .last    (mul_last),
        .product (product)
    );

    // After a MULT completes, result_o tracks LO until the next single-cycle op.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_q <= '0;
            branch_q <= 1'b0;
            sel_mul  <= 1'b0;
            op_done  <= 1'b0;
        end else begin
            op_done <= accept_op;
            if (accept_op) begin
                result_q <= op_result;
                branch_q <= op_branch;
                sel_mul  <= 1'b0;
            end else if (mul_last) begin
                branch_q <= 1'b0;
                sel_mul  <= 1'b1;
            end
        end
    end

    assign hi_o     = product[2*WIDTH-1:WIDTH];
    assign lo_o     = product[WIDTH-1:0];
    assign result_o = sel_mul ? lo_o : result_q;
    assign branch_o = branch_q;
    assign done_o   = op_done | mul_done;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit; MULT latency expectations follow MULT_EARLY_EXIT_EN.
module tb_alu_exec_unit;
    import alu_pkg::*;

`ifdef MULT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [3:0]  ctrl_i = 4'd0;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic [4:0]  shamt_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        branch_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .shamt_i  (shamt_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .branch_o (branch_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s);
        start_i = 1'b1;
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        shamt_i = s;
        tick();
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},   64'(busy_o),   64'd0);
        check({tag, "_done"},   64'(done_o),   64'd0);
        check({tag, "_result"}, 64'(result_o), 64'd0);
        check({tag, "_branch"}, 64'(branch_o), 64'd0);
        check({tag, "_hi"},     64'(hi_o),     64'd0);
        check({tag, "_lo"},     64'(lo_o),     64'd0);
    endtask

    // Issues a MULT, pokes an ignored ADD start at the following edge, then waits for done.
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input int lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] prev_result;
        logic [31:0] prev_hi;
        int n;
        int busy_seen;
        prev_result = result_o;
        prev_hi = hi_o;
        issue(ALU_MULT, a, b, 5'd0);
        check({tag, "_busy_k"}, 64'(busy_o), 64'd1);
        check({tag, "_hold_k"}, 64'(result_o), 64'(prev_result));
        start_i = 1'b1;
        ctrl_i  = ALU_ADD;
        src1_i  = 32'd100;
        src2_i  = 32'd200;
        n = 0;
        busy_seen = 1;
        do begin
            tick();
            n++;
            start_i = 1'b0;
            if (n == 1 && lat > 1) begin
                check({tag, "_ignored_done"}, 64'(done_o), 64'd0);
                check({tag, "_hi_hold"}, 64'(hi_o), 64'(prev_hi));
            end
            if (!done_o && busy_o) busy_seen++;
        end while (!done_o && n < 200);
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_busy_cycles"}, 64'(busy_seen), 64'(lat));
        check({tag, "_busy_end"}, 64'(busy_o), 64'd0);
        check({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
        check({tag, "_result"}, 64'(result_o), 64'(exp_lo));
        check({tag, "_branch"}, 64'(branch_o), 64'd0);
        tick();
        check({tag, "_done_pulse"}, 64'(done_o), 64'd0);
        check({tag, "_result_hold"}, 64'(result_o), 64'(exp_lo));
    endtask

    typedef struct {
        logic [3:0]  code;
        logic [31:0] exp;
        string       name;
    } op_vec_t;

    op_vec_t vecs[7];

    initial begin
        int quiet;

        // Asynchronous reset before the first clock edge.
        #2 rst_i = 1'b0;
        #1 check_idle_zero("reset_async");
        tick();
        tick();
        rst_i = 1'b1;
        check_idle_zero("reset_hold");

        // ADD then SUB back to back.
        issue(ALU_ADD, 32'd7, 32'd9, 5'd0);
        check("add_result", 64'(result_o), 64'd16);
        check("add_done", 64'(done_o), 64'd1);
        check("add_busy", 64'(busy_o), 64'd0);
        ctrl_i = ALU_SUB;
        tick();
        check("sub_result", 64'(result_o), 64'hFFFF_FFFE);
        check("sub_done", 64'(done_o), 64'd1);
        start_i = 1'b0;
        tick();
        check("idle_done", 64'(done_o), 64'd0);
        check("idle_result_hold", 64'(result_o), 64'hFFFF_FFFE);

        // BEQ / BNE with equal operands.
        issue(ALU_BEQ, 32'h55, 32'h55, 5'd0);
        check("beq_branch", 64'(branch_o), 64'd1);
        check("beq_result", 64'(result_o), 64'd0);
        ctrl_i = ALU_BNE;
        tick();
        check("bne_branch", 64'(branch_o), 64'd0);
        check("bne_result", 64'(result_o), 64'd0);

        // SLT signed and SLL to the top bit.
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("slt_result", 64'(result_o), 64'd1);
        issue(ALU_SLL, 32'd0, 32'd1, 5'd31);
        check("sll_result", 64'(result_o), 64'h8000_0000);
        check("sll_branch", 64'(branch_o), 64'd0);

        // Remaining single-cycle codes on a shared operand pair.
        vecs[0] = '{ALU_AND,  32'h00F0_0224, "and"};
        vecs[1] = '{ALU_OR,   32'hFFF0_9775, "or"};
        vecs[2] = '{ALU_SRLV, 32'h0000_00FF, "srlv"};
        vecs[3] = '{ALU_LUI,  32'h8765_0000, "lui"};
        vecs[4] = '{ALU_ORI,  32'hF0F0_9775, "ori"};
        vecs[5] = '{ALU_ADD,  32'h00E0_9999, "add_wrap"};
        vecs[6] = '{4'd13,    32'h0000_0000, "nop13"};
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].code, 32'hF0F0_1234, 32'h0FF0_8765, 5'd0);
            check({vecs[i].name, "_result"}, 64'(result_o), 64'(vecs[i].exp));
            check({vecs[i].name, "_done"}, 64'(done_o), 64'd1);
        end

        // Leave branch_o set so the MULT completion has to clear it.
        issue(ALU_BEQ, 32'h1, 32'h1, 5'd0);
        start_i = 1'b0;
        tick();

        run_mult("mul_neg3x7", 32'hFFFF_FFFD, 32'd7, EARLY ? 3 : 32,
                 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_mult("mul_minxmin", 32'h8000_0000, 32'h8000_0000, 32,
                 32'h4000_0000, 32'h0000_0000);
        run_mult("mul_5x1", 32'd5, 32'd1, EARLY ? 1 : 32,
                 32'h0000_0000, 32'h0000_0005);

        // A single-cycle op after MULT takes result_o back from LO.
        issue(ALU_OR, 32'h10, 32'h01, 5'd0);
        start_i = 1'b0;
        check("post_mul_or", 64'(result_o), 64'h11);
        check("post_mul_lo_hold", 64'(lo_o), 64'd5);

        // Reset in the middle of a long multiply aborts it.
        issue(ALU_MULT, 32'h0001_2345, 32'hFFFF_FFFF, 5'd0);
        start_i = 1'b0;
        tick();
        tick();
        #2 rst_i = 1'b0;
        #1 check_idle_zero("reset_mid_mul");
        rst_i = 1'b1;
        quiet = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_o || busy_o || hi_o != 0 || lo_o != 0) quiet = 0;
        end
        check("reset_mid_mul_quiet", 64'(quiet), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
